// File: rtl/tone_voice.sv
// tone_voice: single-voice 12-TET square-wave tone generator driven by 8-bit note messages.
// Build option VOICE_ENVELOPE_EN adds the PWM decay/release amplitude envelope.
module tone_voice #(
    parameter int CLK_FREQ    = 120_000_000,
    parameter int DECAY_DIV   = 941_176,
    parameter int RELEASE_DIV = 47_059
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    input  logic [7:0] msg,
    output logic       wave,
    output logic       active,
    output logic [6:0] cur_note
);

    typedef enum logic [1:0] {IDLE, SUSTAIN, RELEASE} state_t;

    // Octave-5 half periods in clock cycles; lower octaves are shifted copies.
    function automatic logic [19:0] oct5_half(input int semi);
        real f;
        case (semi)
            0:       f = 523.2511306;
            1:       f = 554.3652620;
            2:       f = 587.3295358;
            3:       f = 622.2539674;
            4:       f = 659.2551138;
            5:       f = 698.4564629;
            6:       f = 739.9888454;
            7:       f = 783.9908720;
            8:       f = 830.6093952;
            9:       f = 880.0;
            10:      f = 932.3275230;
            11:      f = 987.7666025;
            default: f = 0.0;
        endcase
        if (f == 0.0) begin
            return 20'd1;
        end
        return 20'($rtoi(real'(CLK_FREQ) / (2.0 * f) + 0.5));
    endfunction

    if (CLK_FREQ < 8 || DECAY_DIV < 1 || RELEASE_DIV < 1 ||
        DECAY_DIV > 1_048_576 || RELEASE_DIV > 1_048_576) begin : g_bad_param
        $error("tone_voice: parameter out of range");
    end

    logic [19:0] half5 [16];
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_half5
        localparam logic [19:0] HP = oct5_half(gi);
        assign half5[gi] = HP;
    end

    state_t      state_reg, state_next;
    logic [6:0]  note_reg, note_next;
    logic [19:0] tone_cnt_reg, tone_cnt_next;
    logic        phase_reg, phase_next;
    logic        wave_reg;
    logic        gate;

    logic [6:0]  msg_id;
    logic        note_on, note_rest, note_off_match;
    logic [6:0]  note_idx;
    logic [3:0]  semi;
    logic [1:0]  oct_shift;
    logic [19:0] half_period;
    logic        tone_wrap;

    assign msg_id         = msg[6:0];
    assign note_on        = msg_valid && msg[7] && (msg_id >= 7'd1) && (msg_id <= 7'd36);
    assign note_rest      = msg_valid && msg[7] && (msg_id == 7'd0);
    assign note_off_match = msg_valid && !msg[7] && (msg_id == note_reg) && (state_reg == SUSTAIN);

    assign note_idx = note_reg - 7'd1;

    always_comb begin
        semi      = note_idx[3:0];
        oct_shift = 2'd2;
        if (note_idx >= 7'd24) begin
            semi      = 4'(note_idx - 7'd24);
            oct_shift = 2'd0;
        end else if (note_idx >= 7'd12) begin
            semi      = 4'(note_idx - 7'd12);
            oct_shift = 2'd1;
        end
    end

    assign half_period = half5[semi] << oct_shift;
    assign tone_wrap   = (tone_cnt_reg == half_period - 20'd1);

`ifdef VOICE_ENVELOPE_EN
    localparam logic [19:0] DECAY_LIM   = 20'(DECAY_DIV - 1);
    localparam logic [19:0] RELEASE_LIM = 20'(RELEASE_DIV - 1);

    logic [7:0]  amp_reg, amp_next;
    logic [19:0] div_reg, div_next;
    logic [7:0]  pwm_cnt_reg;
    logic [19:0] div_limit;

    assign div_limit = (state_reg == SUSTAIN) ? DECAY_LIM : RELEASE_LIM;
    assign gate      = (pwm_cnt_reg < amp_reg);
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        state_next    = state_reg;
        note_next     = note_reg;
        tone_cnt_next = tone_cnt_reg;
        phase_next    = phase_reg;
`ifdef VOICE_ENVELOPE_EN
        amp_next      = amp_reg;
        div_next      = div_reg;
`endif
        if (state_reg != IDLE) begin
            if (tone_wrap) begin
                tone_cnt_next = '0;
                phase_next    = !phase_reg;
            end else begin
                tone_cnt_next = tone_cnt_reg + 20'd1;
            end
`ifdef VOICE_ENVELOPE_EN
            if (div_reg == div_limit) begin
                div_next = '0;
                amp_next = amp_reg - 8'd1;
                if (amp_reg == 8'd1) begin
                    state_next = IDLE;
                    note_next  = '0;
                end
            end else begin
                div_next = div_reg + 20'd1;
            end
`endif
        end

        // Messages override the envelope step taken on the same edge.
        if (note_on) begin
            state_next    = SUSTAIN;
            note_next     = msg_id;
            tone_cnt_next = '0;
            phase_next    = 1'b1;
`ifdef VOICE_ENVELOPE_EN
            amp_next      = 8'd255;
            div_next      = '0;
`endif
        end else if (note_rest) begin
            state_next = IDLE;
            note_next  = '0;
`ifdef VOICE_ENVELOPE_EN
            amp_next   = 8'd0;
`endif
        end else if (note_off_match) begin
`ifdef VOICE_ENVELOPE_EN
            state_next = RELEASE;
            note_next  = note_reg;
            amp_next   = amp_reg;
            div_next   = '0;
`else
            state_next = IDLE;
            note_next  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            note_reg     <= '0;
            tone_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            wave_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            note_reg     <= note_next;
            tone_cnt_reg <= tone_cnt_next;
            phase_reg    <= phase_next;
            wave_reg     <= (state_reg != IDLE) && phase_reg && gate;
        end
    end

`ifdef VOICE_ENVELOPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            amp_reg     <= '0;
            div_reg     <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            amp_reg     <= amp_next;
            div_reg     <= div_next;
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
        end
    end
`endif

    assign wave     = wave_reg;
    assign active   = (state_reg != IDLE);
    assign cur_note = note_reg;

endmodule

// File: tb/tb_tone_voice.sv
// Testbench for tone_voice: directed and random messages checked every cycle against a
// closed-form timing model (elapsed cycles since note-on / note-off / reset).
module tb_tone_voice;

    localparam int CLK_FREQ    = 1_200_000;
    localparam int DECAY_DIV   = 4;
    localparam int RELEASE_DIV = 1;
`ifdef VOICE_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       msg_valid = 1'b0;
    logic [7:0] msg = 8'h00;
    logic       wave;
    logic       active;
    logic [6:0] cur_note;

    always #5 clk = ~clk;

    tone_voice #(
        .CLK_FREQ(CLK_FREQ),
        .DECAY_DIV(DECAY_DIV),
        .RELEASE_DIV(RELEASE_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .msg_valid(msg_valid),
        .msg(msg),
        .wave(wave),
        .active(active),
        .cur_note(cur_note)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: state 0 idle / 1 sustain / 2 release, plus the edges where timebases restarted.
    int m_st = 0, m_note = 0, m_t0 = 0, m_tr = 0, m_ar = 0;

    function automatic int half_of(input int note);
        int  idx  = note - 1;
        int  semi = idx % 12;
        int  oct  = idx / 12;
        real f5   = 880.0 * $pow(2.0, (semi - 9) / 12.0);
        int  base = $rtoi(CLK_FREQ / (2.0 * f5) + 0.5);
        return base << (2 - oct);
    endfunction

    function automatic int amp_at(input int c);
        int a;
        if (!ENV) return 255;
        case (m_st)
            1:       a = 255 - (c - m_t0) / DECAY_DIV;
            2:       a = m_ar - (c - m_tr) / RELEASE_DIV;
            default: a = 0;
        endcase
        return (a < 0) ? 0 : a;
    endfunction

    // Value the wave output takes one edge after edge c.
    function automatic bit wave_after(input int c);
        if (m_st == 0) return 1'b0;
        if ((((c - m_t0) / half_of(m_note)) % 2) != 0) return 1'b0;
        return !ENV || ((c % 256) < amp_at(c));
    endfunction

    task automatic resolve(input int c);
        if (ENV && m_st != 0 && amp_at(c) == 0) begin
            m_st   = 0;
            m_note = 0;
        end
    endtask

    task automatic model_msg(input logic [7:0] m, input int c);
        int id = int'(m[6:0]);
        if (m[7]) begin
            if (id >= 1 && id <= 36) begin
                m_st = 1; m_note = id; m_t0 = c;
            end else if (id == 0) begin
                m_st = 0; m_note = 0;
            end
        end else if (m_st == 1 && id == m_note) begin
            if (ENV) begin
                m_ar = amp_at(c - 1); m_tr = c; m_st = 2;
            end else begin
                m_st = 0; m_note = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] m);
        bit exp_w;
        exp_w     = wave_after(cyc);
        msg_valid = v;
        msg       = m;
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        cyc++;
        if (v) model_msg(m, cyc);
        resolve(cyc);
        check("wave", 32'(wave), 32'(exp_w));
        check("active", 32'(active), 32'(m_st != 0));
        check("cur_note", 32'(cur_note), 32'(m_note));
        if (v) $display("cyc=%0d msg=0x%02h active=%0b cur_note=%0d", cyc, m, active, cur_note);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        msg_valid = 1'b0;
        msg       = 8'h00;
        repeat (n) @(posedge clk);
        #1;
        rst  = 1'b0;
        cyc  = 0;
        m_st = 0; m_note = 0; m_t0 = 0; m_tr = 0; m_ar = 0;
        check("rst_wave", 32'(wave), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_cur_note", 32'(cur_note), 32'd0);
        $display("reset %0d cycles: wave=%0b active=%0b cur_note=%0d", n, wave, active, cur_note);
    endtask

    function automatic logic [7:0] rand_msg();
        int r = int'($urandom_range(0, 99));
        if (r < 40) return {1'b1, 7'($urandom_range(1, 36))};
        if (r < 65) return {1'b0, 7'(m_note)};
        if (r < 75) return {1'b0, 7'($urandom_range(0, 127))};
        if (r < 80) return 8'h80;
        return {1'b1, 7'($urandom_range(37, 127))};
    endfunction

    initial begin
        int n;

        // Reset, then a long idle stretch.
        do_reset(3);
        repeat (10_000) step(1'b0, 8'h00);

        // Pitch: A4 (id 22), over more than one full period.
        step(1'b1, 8'h96);
        repeat (3000) step(1'b0, 8'h00);
        step(1'b1, 8'h80);

        // Envelope: id 25 held for 20 decay steps, mismatched note-off, then release.
        step(1'b1, 8'h99);
        repeat (80) step(1'b0, 8'h00);
        step(1'b1, 8'h18);
        step(1'b1, 8'h19);
        n = 0;
        while (active === 1'b1 && n < 400) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("release_len", 32'(n), ENV ? 32'd235 : 32'd0);

        // Note-off while idle.
        step(1'b1, 8'h05);
        repeat (10) step(1'b0, 8'h00);

        // Release, invalid note-on, then a real retrigger.
        step(1'b1, 8'h96);
        repeat (40) step(1'b0, 8'h00);
        step(1'b1, 8'h16);
        repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'hA5);
        repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'h99);
        repeat (300) step(1'b0, 8'h00);

        // Rest during a note, then reset during a note.
        step(1'b1, 8'h8A);
        repeat (50) step(1'b0, 8'h00);
        step(1'b1, 8'h80);
        repeat (20) step(1'b0, 8'h00);
        step(1'b1, 8'h8A);
        repeat (30) step(1'b0, 8'h00);
        do_reset(1);
        repeat (20) step(1'b0, 8'h00);

        // Back-to-back strobes.
        step(1'b1, 8'h8C);
        step(1'b1, 8'h0C);
        step(1'b1, 8'h91);
        repeat (50) step(1'b0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 20_000; i++) begin
            if ($urandom_range(0, 4999) == 0) begin
                do_reset(1);
            end else if ($urandom_range(0, 47) == 0) begin
                step(1'b1, rand_msg());
            end else begin
                step(1'b0, 8'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
